// File: rtl/signed_divider.sv
// 16/8 signed restoring divider: IDLE -> CALC (16 steps, MSB first) -> FIX (sign apply, done pulse).
// Define DIV_SATURATE_EN to saturate the -32768/-1 quotient to 16'h7FFF instead of wrapping to 16'h8000.
module signed_divider (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] dividend,
  input  logic [7:0]  divisor,
  output logic        busy,
  output logic        done,
  output logic [15:0] quotient,
  output logic [7:0]  remainder,
  output logic        div_by_zero,
  output logic        overflow
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]  r_state;
  logic [3:0]  r_cnt;
  logic        r_dz;
  logic        r_dvd_neg;
  logic        r_dvs_neg;
  logic [15:0] r_qshift;
  logic [7:0]  r_dvs_mag;
  logic [7:0]  r_rem;

  logic signed [15:0] w_dvd_s;
  logic signed [7:0]  w_dvs_s;
  logic [8:0]         w_shift;
  logic               w_ge;
  logic [7:0]         w_diff;
  logic               w_q_neg;
  logic               w_ovf;
  logic [15:0]        w_q_fix;
  logic [7:0]         w_r_fix;

  function automatic logic [15:0] mag16(input logic signed [15:0] x);
    mag16 = x[15] ? 16'(-x) : 16'(x);
  endfunction

  function automatic logic [7:0] mag8(input logic signed [7:0] x);
    mag8 = x[7] ? 8'(-x) : 8'(x);
  endfunction

  function automatic logic [15:0] apply_sign16(input logic [15:0] m, input logic neg);
    apply_sign16 = neg ? 16'(-m) : m;
  endfunction

  function automatic logic [7:0] apply_sign8(input logic [7:0] m, input logic neg);
    apply_sign8 = neg ? 8'(-m) : m;
  endfunction

  // Only -32768 / -1 reaches here with ovf set; the wrapped value is already 16'h8000.
  function automatic logic [15:0] sat_quotient(input logic [15:0] q, input logic ovf);
`ifdef DIV_SATURATE_EN
    sat_quotient = ovf ? 16'h7FFF : q;
`else
    sat_quotient = ovf ? 16'h8000 : q;
`endif
  endfunction

  assign w_dvd_s = dividend;
  assign w_dvs_s = divisor;

  // CALC step: bring in the next dividend bit, subtract the divisor if it fits
  assign w_shift = {r_rem, r_qshift[15]};
  assign w_ge    = (w_shift >= {1'b0, r_dvs_mag});
  assign w_diff  = w_shift[7:0] - r_dvs_mag;

  // FIX: r_qshift now holds the unsigned quotient magnitude
  assign w_q_neg = r_dvd_neg ^ r_dvs_neg;
  assign w_ovf   = !w_q_neg && r_qshift[15];
  assign w_q_fix = sat_quotient(apply_sign16(r_qshift, w_q_neg), w_ovf);
  assign w_r_fix = apply_sign8(r_rem, r_dvd_neg);

  assign busy = (r_state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_dz        <= 1'b0;
      done        <= 1'b0;
      quotient    <= 16'd0;
      remainder   <= 8'd0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cnt   <= 4'd0;
            r_dz    <= (divisor == 8'd0);
            r_state <= (divisor == 8'd0) ? S_FIX : S_CALC;
          end
        end
        S_CALC: begin
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt == 4'd15) r_state <= S_FIX;
        end
        S_FIX: begin
          if (r_dz) begin
            quotient    <= 16'd0;
            remainder   <= 8'd0;
            div_by_zero <= 1'b1;
            overflow    <= 1'b0;
          end else begin
            quotient    <= w_q_fix;
            remainder   <= w_r_fix;
            div_by_zero <= 1'b0;
            overflow    <= w_ovf;
          end
          done    <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Datapath registers carry no reset; they are always loaded before use
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && start) begin
      r_dvd_neg <= w_dvd_s[15];
      r_dvs_neg <= w_dvs_s[7];
      r_qshift  <= mag16(w_dvd_s);
      r_dvs_mag <= mag8(w_dvs_s);
      r_rem     <= 8'd0;
    end else if (r_state == S_CALC) begin
      r_qshift <= {r_qshift[14:0], w_ge};
      r_rem    <= w_ge ? w_diff : w_shift[7:0];
    end
  end

endmodule
